johnson_phase_decoder: RTL and testbench
========================================

JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 4, range 2..15: consecutive legal in-sequence codes needed to declare lock.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-high.
REQ-004 code_in  input  8  Johnson-counter word from the upstream 8-bit twisted-ring stage.
REQ-005 code_valid  input  1  code_in is sampled only when this is high.
REQ-006 phase  output  4  decoded phase index 0..15 of the last accepted code.
REQ-007 phase_valid  output  1  one-cycle strobe: phase updated while locked.
REQ-008 locked  output  1  high while in LOCKED.
REQ-009 wrap_pulse  output  1  one-cycle strobe on a locked 15->0 phase transition.
REQ-010 rev_count  output  8  number of locked wraps, modulo 256.
REQ-011 seq_err  output  1  one-cycle strobe on loss of lock.
REQ-012 err_count  output  8  lock-loss count, saturating at 255 (present only with JPD_ERRCNT_EN).

Function
REQ-013 Legal code table SHALL be, phase 0..15: 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80 (hex); the other 240 values are illegal.
REQ-014 Decode SHALL be combinational from code_in; all outputs SHALL be registered, latency 1 cycle from the sampling edge.
REQ-015 Cycles with code_valid low SHALL change no state and assert no strobe; there is no timeout.
REQ-016 FSM states SHALL be SEARCH, TRACK, LOCKED; expected = (last accepted phase + 1) mod 16; streak 4-bit counter.
REQ-017 SEARCH: legal valid code -> TRACK, streak=1, phase loaded; illegal -> stay SEARCH.
REQ-018 TRACK: legal code equal to expected -> streak+1, phase loaded; when streak reaches LOCK_COUNT -> LOCKED, locked high next cycle.
REQ-019 TRACK: legal code not equal to expected -> stay TRACK, streak=1, phase reloaded (restart); illegal -> SEARCH, streak=0.
REQ-020 LOCKED: code equal to expected -> phase loaded, phase_valid strobe; if transition is 15->0, wrap_pulse strobe and rev_count+1 (wraps 255->0).
REQ-021 LOCKED: any other valid code (repeat, skip, illegal) -> seq_err strobe, locked low next cycle, phase holds, state SEARCH, err_count+1.
REQ-022 A repeated identical code in TRACK or LOCKED SHALL count as a mismatch.
REQ-023 phase_valid SHALL be low in SEARCH and TRACK; the locking code itself SHALL produce phase_valid.

Reset
REQ-024 rst_n high SHALL immediately force SEARCH, streak=0, phase=0, all strobes 0, locked=0, rev_count=0, err_count=0.
REQ-025 Reset asserted mid-lock SHALL drop locked without a seq_err strobe or err_count increment.
REQ-026 After rst_n falls, first valid code is sampled on the next rising edge.

Configuration
REQ-027 Macro JPD_ERRCNT_EN: when defined, err_count port and saturating counter exist per REQ-012/021.
REQ-028 Without JPD_ERRCNT_EN: no err_count port or counter; seq_err behaviour is unchanged.

Structure
REQ-029 Shared package jpd_pkg SHALL hold the FSM state enum, the 16-entry legal-code constant table and the LOCK_COUNT default.
REQ-030 Sub-module johnson_code_lut (combinational: code -> {legal, phase}) SHALL be instantiated once.

Verification
REQ-031 Reset, then feed 00,01,03,07 valid consecutively -> locked=1 one cycle after 07 sampled, phase=3, phase_valid pulse with that code.
REQ-032 Locked, feed 7F..80,00 -> wrap_pulse one cycle after 00 sampled, rev_count 0->1; 256 wraps -> rev_count returns to 0.
REQ-033 Locked at phase 5 (1F), feed 55 -> seq_err pulse, locked=0, err_count=1, phase stays 5; 300 such losses -> err_count=255.
REQ-034 TRACK after 00,01, feed 0F -> streak restarts at 1, no lock until 1F,3F,7F follow (LOCK_COUNT=4).
REQ-035 Locked, code_valid low 20 cycles with code_in=AA -> no state change, no strobes, locked stays 1.
REQ-036 Locked, assert rst_n mid-cycle -> all outputs 0 immediately, seq_err never asserted, err_count=0.

Source files
------------

// File: rtl/jpd_pkg.sv
// -----------------------------------------------------------------------------
// jpd_pkg
// Shared definitions for the Johnson phase decoder slice:
//   - jpd_state_e      : lock FSM states (SEARCH, TRACK, LOCKED)
//   - JPD_LOCK_COUNT_DEF : default number of in-sequence codes needed to lock
//   - JPD_CODE_TABLE   : the 16 legal 8-bit twisted-ring words, indexed by phase
//   - jpd_next_phase   : successor phase, wrapping 15 -> 0
// -----------------------------------------------------------------------------
package jpd_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } jpd_state_e;

    localparam int JPD_LOCK_COUNT_DEF = 4;
    localparam int JPD_NUM_PHASES     = 16;

    // Phase 0..7 shift ones in from the LSB, phase 8..15 shift zeros in.
    localparam logic [7:0] JPD_CODE_TABLE [0:JPD_NUM_PHASES-1] = '{
        8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
        8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80
    };

    function automatic logic [3:0] jpd_next_phase(input logic [3:0] p);
        return p + 4'd1;
    endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// -----------------------------------------------------------------------------
// johnson_phase_decoder_if
// Bundles the code input and the decoded status outputs of the decoder.
//   code_in/code_valid : Johnson word from upstream and its qualifier
//   phase/phase_valid  : decoded phase and locked-update strobe
//   locked             : decoder is in lock
//   wrap_pulse/rev_count : 15->0 strobe and modulo-256 wrap counter
//   seq_err            : loss-of-lock strobe
//   err_count          : saturating loss counter (only with JPD_ERRCNT_EN)
// Modports: master drives codes (upstream/bench), slave is the decoder.
// -----------------------------------------------------------------------------
interface johnson_phase_decoder_if;

    logic [7:0] code_in;
    logic       code_valid;
    logic [3:0] phase;
    logic       phase_valid;
    logic       locked;
    logic       wrap_pulse;
    logic [7:0] rev_count;
    logic       seq_err;
`ifdef JPD_ERRCNT_EN
    logic [7:0] err_count;
`endif

    modport master (
        output code_in,
        output code_valid,
        input  phase,
        input  phase_valid,
        input  locked,
        input  wrap_pulse,
        input  rev_count,
        input  seq_err
`ifdef JPD_ERRCNT_EN
        ,
        input  err_count
`endif
    );

    modport slave (
        input  code_in,
        input  code_valid,
        output phase,
        output phase_valid,
        output locked,
        output wrap_pulse,
        output rev_count,
        output seq_err
`ifdef JPD_ERRCNT_EN
        ,
        output err_count
`endif
    );

endinterface

// File: rtl/johnson_code_lut.sv
// -----------------------------------------------------------------------------
// johnson_code_lut
// Combinational decode of an 8-bit Johnson word into its phase index.
//   code_i  : candidate word
//   legal_o : word is one of the 16 legal twisted-ring states
//   phase_o : phase index of the word (0 when illegal)
// -----------------------------------------------------------------------------
module johnson_code_lut
    import jpd_pkg::*;
(
    input  logic [7:0] code_i,
    output logic       legal_o,
    output logic [3:0] phase_o
);

    always_comb begin
        legal_o = 1'b0;
        phase_o = 4'd0;
        for (int i = 0; i < JPD_NUM_PHASES; i++) begin
            if (code_i == JPD_CODE_TABLE[i]) begin
                legal_o = 1'b1;
                phase_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// -----------------------------------------------------------------------------
// johnson_phase_decoder
// Tracks an 8-bit Johnson counter stream, declares lock after LOCK_COUNT
// consecutive in-sequence legal codes and reports phase, wraps and lock loss.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active HIGH (legacy name kept)
//   bus   : johnson_phase_decoder_if.slave (code input, status outputs)
// Parameter LOCK_COUNT (2..15): in-sequence codes required to lock.
// Optional: define JPD_ERRCNT_EN to add the saturating err_count output.
// All outputs are registered; latency is one cycle from the sampling edge.
// -----------------------------------------------------------------------------
module johnson_phase_decoder
    import jpd_pkg::*;
#(
    parameter int LOCK_COUNT = JPD_LOCK_COUNT_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    johnson_phase_decoder_if.slave bus
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    logic       code_legal;
    logic [3:0] code_phase;

    johnson_code_lut u_lut (
        .code_i  (bus.code_in),
        .legal_o (code_legal),
        .phase_o (code_phase)
    );

    jpd_state_e state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic [3:0] phase_q, phase_d;
    logic       pvld_q, pvld_d;
    logic       locked_q, locked_d;
    logic       wrap_q, wrap_d;
    logic [7:0] rev_q, rev_d;
    logic       serr_q, serr_d;
`ifdef JPD_ERRCNT_EN
    logic [7:0] err_q, err_d;
`endif

    logic [3:0] expected;
    logic       in_seq;
    logic [3:0] streak_inc;

    assign expected   = jpd_next_phase(phase_q);
    assign in_seq     = code_legal && (code_phase == expected);
    assign streak_inc = streak_q + 4'd1;

    // ---- next-state / output decode ----
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        phase_d  = phase_q;
        pvld_d   = 1'b0;
        wrap_d   = 1'b0;
        rev_d    = rev_q;
        serr_d   = 1'b0;
`ifdef JPD_ERRCNT_EN
        err_d    = err_q;
`endif
        if (bus.code_valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (code_legal) begin
                        state_d  = TRACK;
                        streak_d = 4'd1;
                        phase_d  = code_phase;
                    end
                end
                TRACK: begin
                    if (!code_legal) begin
                        state_d  = SEARCH;
                        streak_d = 4'd0;
                    end else if (in_seq) begin
                        streak_d = streak_inc;
                        phase_d  = code_phase;
                        // The code that completes the streak is itself reported.
                        if (streak_inc >= LOCK_CNT) begin
                            state_d = LOCKED;
                            pvld_d  = 1'b1;
                        end
                    end else begin
                        // Out-of-sequence legal code (incl. a repeat) restarts the run.
                        streak_d = 4'd1;
                        phase_d  = code_phase;
                    end
                end
                LOCKED: begin
                    if (in_seq) begin
                        phase_d = code_phase;
                        pvld_d  = 1'b1;
                        if (code_phase == 4'd0) begin
                            wrap_d = 1'b1;
                            rev_d  = rev_q + 8'd1;
                        end
                    end else begin
                        // Phase is held at the last good value on loss of lock.
                        state_d  = SEARCH;
                        streak_d = 4'd0;
                        serr_d   = 1'b1;
`ifdef JPD_ERRCNT_EN
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_d  = SEARCH;
                    streak_d = 4'd0;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    // ---- state and output registers ----
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= SEARCH;
            streak_q <= 4'd0;
            phase_q  <= 4'd0;
            pvld_q   <= 1'b0;
            locked_q <= 1'b0;
            wrap_q   <= 1'b0;
            rev_q    <= 8'd0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            phase_q  <= phase_d;
            pvld_q   <= pvld_d;
            locked_q <= locked_d;
            wrap_q   <= wrap_d;
            rev_q    <= rev_d;
            serr_q   <= serr_d;
        end
    end

`ifdef JPD_ERRCNT_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_count = err_q;
`endif

    assign bus.phase       = phase_q;
    assign bus.phase_valid = pvld_q;
    assign bus.locked      = locked_q;
    assign bus.wrap_pulse  = wrap_q;
    assign bus.rev_count   = rev_q;
    assign bus.seq_err     = serr_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// -----------------------------------------------------------------------------
// tb_johnson_phase_decoder
// Self-checking bench for johnson_phase_decoder (LOCK_COUNT = 4): a vector
// table, directed multi-cycle sequences and a randomized run compared with a
// behavioural reference model. err_count checks exist only with JPD_ERRCNT_EN.
// -----------------------------------------------------------------------------
module tb_johnson_phase_decoder;

    localparam int LC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    johnson_phase_decoder_if bus ();

    johnson_phase_decoder #(.LOCK_COUNT(LC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] tbl [0:15] = '{
        8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
        8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80
    };

    typedef struct {
        logic [7:0] code;
        logic       vld;
        logic [3:0] ph;
        logic       pv;
        logic       lk;
        logic       serr;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ph, input logic pv,
                           input logic lk, input logic wr, input logic se);
        chk({tag, " phase"}, 32'(bus.phase), 32'(ph));
        chk({tag, " phase_valid"}, 32'(bus.phase_valid), 32'(pv));
        chk({tag, " locked"}, 32'(bus.locked), 32'(lk));
        chk({tag, " wrap_pulse"}, 32'(bus.wrap_pulse), 32'(wr));
        chk({tag, " seq_err"}, 32'(bus.seq_err), 32'(se));
    endtask

    task automatic step(input logic [7:0] c, input logic v);
        @(negedge clk);
        bus.code_in    = c;
        bus.code_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.code_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    // ---------------- reference model ----------------
    int m_run, m_last, m_rev, m_err;
    bit m_lock;
    bit e_pv, e_wrap, e_serr;

    function automatic int idx_of(input logic [7:0] c);
        for (int i = 0; i < 16; i++) if (tbl[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_last = 0; m_rev = 0; m_err = 0; m_lock = 0;
        e_pv = 0; e_wrap = 0; e_serr = 0;
    endtask

    task automatic model_step(input logic [7:0] c, input logic v);
        int idx;
        e_pv = 0; e_wrap = 0; e_serr = 0;
        if (v) begin
            idx = idx_of(c);
            if (m_lock) begin
                if (idx == (m_last + 1) % 16) begin
                    e_pv = 1;
                    if (idx == 0) begin
                        e_wrap = 1;
                        m_rev = (m_rev + 1) % 256;
                    end
                    m_last = idx;
                end else begin
                    e_serr = 1;
                    m_lock = 0;
                    m_run = 0;
                    if (m_err < 255) m_err++;
                end
            end else if (idx < 0) begin
                m_run = 0;
            end else begin
                if (m_run > 0 && idx == (m_last + 1) % 16) m_run++;
                else m_run = 1;
                m_last = idx;
                if (m_run >= LC) begin
                    m_lock = 1;
                    e_pv = 1;
                end
            end
        end
    endtask

    initial begin
        int wraps;
        int serrs;
        logic [7:0] c;
        logic v;
        int r;

        bus.code_in = 8'h00;
        bus.code_valid = 1'b0;

        vecs[0]  = '{8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h01, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h0F, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h1F, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h3F, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'hAA, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h7F, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{8'hFF, 1'b1, 4'd8, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{8'h55, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{8'h55, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'h01, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{8'h03, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{8'h07, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{8'h07, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1};

        // Reset state while reset is held.
        #12;
        chk_out("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset rev_count", 32'(bus.rev_count), 32'd0);
`ifdef JPD_ERRCNT_EN
        chk("reset err_count", 32'(bus.err_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b0;

        // Vector table: restart, valid gaps, lock, loss, relock, repeat.
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].code, vecs[i].vld);
            chk_out($sformatf("vec%0d", i), vecs[i].ph, vecs[i].pv, vecs[i].lk, 1'b0, vecs[i].serr);
        end
        chk("vec rev_count", 32'(bus.rev_count), 32'd0);
`ifdef JPD_ERRCNT_EN
        chk("vec err_count", 32'(bus.err_count), 32'd2);
`endif

        // Lock from reset, then walk to 80 and wrap to 00.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            step(tbl[p], 1'b1);
            chk("prelock locked", 32'(bus.locked), 32'd0);
        end
        step(tbl[3], 1'b1);
        chk_out("lock07", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int p = 4; p < 16; p++) step(tbl[p], 1'b1);
        chk_out("at80", 4'd15, 1'b1, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b1);
        chk_out("wrap00", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("wrap rev_count", 32'(bus.rev_count), 32'd1);

        // 256 further wraps bring rev_count back to 1.
        wraps = 0;
        for (int w = 0; w < 256; w++) begin
            for (int p = 1; p <= 16; p++) begin
                step(tbl[p % 16], 1'b1);
                if (bus.wrap_pulse) wraps++;
            end
        end
        chk("wrap count", 32'(wraps), 32'd256);
        chk("rev_count modulo", 32'(bus.rev_count), 32'd1);
        chk("still locked", 32'(bus.locked), 32'd1);

        // code_valid low for 20 cycles with a garbage word.
        for (int k = 0; k < 20; k++) begin
            step(8'hAA, 1'b0);
            chk_out($sformatf("idle%0d", k), 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("idle rev_count", 32'(bus.rev_count), 32'd1);

        // Reset asserted mid-cycle while locked.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("midreset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midreset rev_count", 32'(bus.rev_count), 32'd0);
        serrs = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (bus.seq_err) serrs++;
        end
        chk("midreset no seq_err", 32'(serrs), 32'd0);
`ifdef JPD_ERRCNT_EN
        chk("midreset err_count", 32'(bus.err_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b0;

        // Lock at phase 5, then illegal code; repeat 300 times.
        for (int p = 0; p < 6; p++) step(tbl[p], 1'b1);
        chk_out("at1F", 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        step(8'h55, 1'b1);
        chk_out("loss55", 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef JPD_ERRCNT_EN
        chk("loss err_count", 32'(bus.err_count), 32'd1);
`endif
        serrs = 1;
        for (int n = 1; n < 300; n++) begin
            for (int p = 0; p < 6; p++) step(tbl[p], 1'b1);
            step(8'h55, 1'b1);
            if (bus.seq_err) serrs++;
        end
        chk("loss pulses", 32'(serrs), 32'd300);
`ifdef JPD_ERRCNT_EN
        chk("err_count saturate", 32'(bus.err_count), 32'd255);
`endif

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int t = 0; t < 3000; t++) begin
            r = int'($urandom_range(0, 99));
            if (r < 65)      c = tbl[(m_last + 1) % 16];
            else if (r < 75) c = tbl[m_last];
            else if (r < 87) c = tbl[$urandom_range(0, 15)];
            else             c = 8'($urandom);
            v = ($urandom_range(0, 9) != 0);
            step(c, v);
            model_step(c, v);
            chk_out($sformatf("rnd%0d", t), 4'(m_last), e_pv, m_lock, e_wrap, e_serr);
            chk($sformatf("rnd%0d rev_count", t), 32'(bus.rev_count), 32'(m_rev));
`ifdef JPD_ERRCNT_EN
            chk($sformatf("rnd%0d err_count", t), 32'(bus.err_count), 32'(m_err));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
